fifo_wr_sync_level: RTL and testbench

Write-domain receiver for the asynchronous FIFO's read pointer. Synchronizes the Gray-coded read pointer into `wr_clk`, decodes it and the local write Gray pointer to binary, and produces:
- the synchronized pointer for the full-flag logic;
- a registered fill level;
- a hysteretic almost-full flag;
- a per-cycle freed-entry count.

It sits beside the write-side full/pointer generator, between the read-domain pointer register and the write-side producer.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/ptr_sync.sv | 21 ++
 rtl/fifo_wr_sync_level.sv | 77 +++++++
 tb/tb_fifo_wr_sync_level.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer coding helpers, depth derivation and almost-full state type
package fifo_pkg;
  typedef enum logic {AF_LOW, AF_HIGH} af_state_t;
  function automatic int depth_of(input int addr_size);
    return 1 << addr_size;
  endfunction
  // Zero-extended inputs decode correctly since leading zero Gray bits stay zero
  function automatic logic [31:0] grey2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [31:0] bin2grey(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/ptr_sync.sv
// ptr_sync: plain multi-flop synchronizer for a Gray-coded pointer
module ptr_sync #(
  parameter int W = 5,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sync_q [STAGES];
  logic [W-1:0] sync_d [STAGES];
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '{default: '0};
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/fifo_wr_sync_level.sv
// fifo_wr_sync_level: write-domain read-pointer receiver with level, almost-full and freed count
module fifo_wr_sync_level
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AF_SET = 14,
  parameter int AF_CLR = 12
) (
  input  logic               wr_clk,
  input  logic               wr_rst,
  input  logic [ADDR_SIZE:0] rd_addr_grey,
  input  logic [ADDR_SIZE:0] wr_addr_grey,
  output logic [ADDR_SIZE:0] rd_ptr_addr_sync,
  output logic [ADDR_SIZE:0] wr_level,
  output logic               almost_full,
  output logic [ADDR_SIZE:0] rd_freed,
  output logic               rd_advance,
  output logic               ptr_err
);
  localparam int PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(depth_of(ADDR_SIZE));
  localparam logic [PW-1:0] AF_SET_P = PW'(AF_SET);
  localparam logic [PW-1:0] AF_CLR_P = PW'(AF_CLR);
  logic [PW-1:0] rd_bin, wr_bin, diff;
  logic [PW-1:0] rd_bin_prev_q, rd_bin_prev_d, wr_level_q, wr_level_d, rd_freed_q, rd_freed_d;
  logic rd_advance_q, rd_advance_d, ptr_err_q, ptr_err_d, bad;
  af_state_t state_q, state_d;
  ptr_sync #(.W(PW), .STAGES(SYNC_STAGES)) u_sync (
    .clk(wr_clk),
    .rst(wr_rst),
    .d  (rd_addr_grey),
    .q  (rd_ptr_addr_sync)
  );
  always_comb begin
    rd_bin = PW'(grey2bin(32'(rd_ptr_addr_sync)));
    wr_bin = PW'(grey2bin(32'(wr_addr_grey)));
    diff = wr_bin - rd_bin;
    bad = diff > DEPTH_P;
    wr_level_d = bad ? wr_level_q : diff;
    ptr_err_d = ptr_err_q | bad;
    rd_freed_d = rd_bin - rd_bin_prev_q;
    rd_advance_d = rd_bin != rd_bin_prev_q;
    rd_bin_prev_d = rd_bin;
  end
  always_ff @(posedge wr_clk or posedge wr_rst)
    if (wr_rst) begin
      rd_bin_prev_q <= '0;
      wr_level_q <= '0;
      rd_freed_q <= '0;
      rd_advance_q <= 1'b0;
      ptr_err_q <= 1'b0;
    end else begin
      rd_bin_prev_q <= rd_bin_prev_d;
      wr_level_q <= wr_level_d;
      rd_freed_q <= rd_freed_d;
      rd_advance_q <= rd_advance_d;
      ptr_err_q <= ptr_err_d;
    end
  always_ff @(posedge wr_clk or posedge wr_rst)
    if (wr_rst) state_q <= AF_LOW;
    else state_q <= state_d;
  // An out-of-range difference is untrustworthy, so the flag holds that cycle
  always_comb begin
    state_d = state_q;
    if (!bad)
      state_d = (state_q == AF_LOW) ? ((diff >= AF_SET_P) ? AF_HIGH : AF_LOW)
                                    : ((diff <= AF_CLR_P) ? AF_LOW : AF_HIGH);
  end
  always_comb begin
    almost_full = state_q == AF_HIGH;
    wr_level = wr_level_q;
    rd_freed = rd_freed_q;
    rd_advance = rd_advance_q;
    ptr_err = ptr_err_q;
  end
endmodule

// File: tb/tb_fifo_wr_sync_level.sv
// tb_fifo_wr_sync_level: directed self-checking bench for the write-side read-pointer receiver
module tb_fifo_wr_sync_level;
  logic wr_clk = 1'b0, wr_rst = 1'b1;
  logic [4:0] rd_addr_grey = '0, wr_addr_grey = '0;
  logic [4:0] rd_ptr_addr_sync, wr_level, rd_freed;
  logic almost_full, rd_advance, ptr_err;
  int checks = 0, passed = 0;
  fifo_wr_sync_level #(.ADDR_SIZE(4), .SYNC_STAGES(2), .AF_SET(14), .AF_CLR(12)) dut (
    .wr_clk(wr_clk),
    .wr_rst(wr_rst),
    .rd_addr_grey(rd_addr_grey),
    .wr_addr_grey(wr_addr_grey),
    .rd_ptr_addr_sync(rd_ptr_addr_sync),
    .wr_level(wr_level),
    .almost_full(almost_full),
    .rd_freed(rd_freed),
    .rd_advance(rd_advance),
    .ptr_err(ptr_err)
  );
  always #5 wr_clk = ~wr_clk;
  function automatic logic [4:0] g(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge wr_clk);
      @(negedge wr_clk);
    end
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_sync"}, 32'(rd_ptr_addr_sync), 0);
    chk({tag, "_level"}, 32'(wr_level), 0);
    chk({tag, "_af"}, 32'(almost_full), 0);
    chk({tag, "_freed"}, 32'(rd_freed), 0);
    chk({tag, "_adv"}, 32'(rd_advance), 0);
    chk({tag, "_err"}, 32'(ptr_err), 0);
  endtask
  initial begin
    tick(3);
    chk_all_zero("por");
    wr_rst = 1'b0;
    tick();
    chk_all_zero("idle");
    for (int i = 1; i <= 5; i++) begin
      wr_addr_grey = g(i);
      tick();
      chk("lat_level", 32'(wr_level), 32'(i));
    end
    rd_addr_grey = 5'b00011;
    tick();
    chk("sync_e1", 32'(rd_ptr_addr_sync), 0);
    tick();
    chk("sync_e2", 32'(rd_ptr_addr_sync), 32'h3);
    chk("level_e2", 32'(wr_level), 5);
    tick();
    chk("level_e3", 32'(wr_level), 3);
    chk("freed_e3", 32'(rd_freed), 2);
    chk("adv_e3", 32'(rd_advance), 1);
    tick();
    chk("freed_e4", 32'(rd_freed), 0);
    chk("adv_e4", 32'(rd_advance), 0);
    for (int b = 6; b <= 18; b++) begin
      wr_addr_grey = g(b);
      tick();
      chk("rise_level", 32'(wr_level), 32'(b - 2));
      chk("rise_af", 32'(almost_full), (b - 2 >= 14) ? 1 : 0);
    end
    rd_addr_grey = g(5);
    tick(3);
    chk("down13_level", 32'(wr_level), 13);
    chk("down13_af", 32'(almost_full), 1);
    rd_addr_grey = g(6);
    tick(3);
    chk("down12_level", 32'(wr_level), 12);
    chk("down12_af", 32'(almost_full), 0);
    wr_addr_grey = g(19);
    tick();
    chk("up13_level", 32'(wr_level), 13);
    chk("up13_af", 32'(almost_full), 0);
    rd_addr_grey = g(19);
    tick(3);
    chk("empty_level", 32'(wr_level), 0);
    wr_addr_grey = g(30);
    tick();
    rd_addr_grey = g(20);
    tick(3);
    chk("pre_wrap_level", 32'(wr_level), 10);
    wr_addr_grey = g(31);
    tick();
    chk("wrap31_level", 32'(wr_level), 11);
    wr_addr_grey = g(0);
    tick();
    chk("wrap0_level", 32'(wr_level), 12);
    rd_addr_grey = g(30);
    tick(3);
    chk("rd30_level", 32'(wr_level), 2);
    wr_addr_grey = g(2);
    tick();
    chk("wr2_level", 32'(wr_level), 4);
    rd_addr_grey = g(1);
    tick(3);
    chk("rwrap_freed", 32'(rd_freed), 3);
    chk("rwrap_adv", 32'(rd_advance), 1);
    chk("rwrap_level", 32'(wr_level), 1);
    tick();
    chk("rwrap_adv_off", 32'(rd_advance), 0);
    chk("rwrap_err", 32'(ptr_err), 0);
    rd_addr_grey = g(2);
    wr_addr_grey = g(10);
    tick(3);
    chk("pre_err_level", 32'(wr_level), 8);
    wr_addr_grey = g(20);
    tick();
    chk("err_set", 32'(ptr_err), 1);
    chk("err_hold_level", 32'(wr_level), 8);
    chk("err_hold_af", 32'(almost_full), 0);
    wr_addr_grey = g(12);
    tick();
    chk("err_sticky", 32'(ptr_err), 1);
    chk("err_legal_level", 32'(wr_level), 10);
    wr_addr_grey = g(11);
    tick();
    chk("mid_level", 32'(wr_level), 9);
    chk("mid_err", 32'(ptr_err), 1);
    wr_rst = 1'b1;
    #1;
    chk_all_zero("rst_async");
    tick(2);
    chk_all_zero("rst_held");
    wr_rst = 1'b0;
    tick();
    chk("post_rst_sync", 32'(rd_ptr_addr_sync), 0);
    chk("post_rst_level", 32'(wr_level), 11);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
